pipe_out_buffer: RTL and testbench
==================================

# pipe_out_buffer

Output buffer and credit manager for the strobe-driven DSP pipelines in sdr_lib. It sits directly downstream of the last pipeline stage, whose valid/tag outputs and per-stage strobes implement the pipeline. The block absorbs completed items into a small FIFO, pops the final stage by asserting its `stb_out`, and presents results on a src_rdy/dst_rdy handshake. A credit counter tells the pipeline controller when it may launch a new item, so items in flight never exceed free buffer space.

## Interface
Parameters:
- `WIDTH`, 32, data width of a result word
- `TAGWIDTH`, 1, tag width, matching the pipeline stage tag
- `DEPTH_LOG2`, 2, log2 of FIFO depth; DEPTH = 2**DEPTH_LOG2

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `launch_i`  in  1  pipeline controller launched a new item this cycle (first stage `stb_in`)
- `ok_to_launch`  out  1  credits available; controller must not assert `launch_i` when low
- `valid_in`  in  1  final stage holds a completed item
- `data_in`  in  WIDTH  final stage result
- `tag_in`  in  TAGWIDTH  final stage tag
- `stb_out`  out  1  pop strobe to final stage; item captured this cycle
- `o_data`  out  WIDTH  head-of-FIFO data
- `o_tag`  out  TAGWIDTH  head-of-FIFO tag
- `src_rdy_o`  out  1  head item valid
- `dst_rdy_i`  in  1  downstream accepts head item
- `count`  out  DEPTH_LOG2+1  FIFO occupancy
- `overflow`  out  1  sticky: item arrived while full
- `underflow`  out  1  sticky: launch with zero credits

## Operation
- Reset (`reset` low, async): wr_ptr = rd_ptr = 0, `count` = 0, credits = DEPTH, `overflow` = `underflow` = 0. Storage array not reset.
- Capture: `stb_out` = `valid_in` & (`count` != DEPTH), combinational. When `stb_out` is high, {`tag_in`,`data_in`} is written at wr_ptr on the edge and wr_ptr increments modulo DEPTH.
- Output: `src_rdy_o` = (`count` != 0). `o_data`/`o_tag` = entry at rd_ptr when `src_rdy_o`, else all zeros. Pop = `src_rdy_o` & `dst_rdy_i`; rd_ptr increments modulo DEPTH.
- Count: +1 on capture only, -1 on pop only, unchanged on both or neither. Write while full is never taken, even if pop occurs in the same cycle; no combinational path from `dst_rdy_i` to `stb_out`.
- Credits (DEPTH_LOG2+1 bits): -1 on `launch_i` only, +1 on pop only, unchanged on both. `ok_to_launch` = (credits != 0).
- Launch at zero credits: credits hold at 0 and `underflow` sets.
- Pop with launch at zero credits: credits hold at 0. The pop increment and failed launch decrement cancel. `underflow` still sets.
- `overflow` sets when `valid_in` & full. Both sticky flags clear only on reset.
- Invariant under legal use: credits + count + in_flight = DEPTH. Credits never exceed DEPTH.
- Pointer wrap: pointers are DEPTH_LOG2 bits and wrap naturally. Full/empty come from `count`, not pointer compare.

## Timing
- Capture to output: item captured at edge N is visible with `src_rdy_o` high in cycle N+1. Minimum latency is one cycle.
- `stb_out` depends only on `valid_in` and registered `count`. The final stage clears its valid at the same edge, unless it reloads.
- Pop at edge N: credit is visible on `ok_to_launch` in cycle N+1.
- Back-to-back: sustains one capture and one pop per cycle when not full.
- All outputs are registered except `stb_out`, `src_rdy_o`, `o_data`, `o_tag`, and `ok_to_launch`, which are decoded from registered state plus `valid_in`.
- Async reset assertion mid-transfer drops `src_rdy_o` and `stb_out` immediately. Deassertion is synchronized by the integrator.

## Test plan
- Reset: `reset` low mid-run -> `count`=0, `src_rdy_o`=0, `o_data`=0, `ok_to_launch`=1, credits=4, flags 0.
- Streaming: `dst_rdy_i`=1, `valid_in` each cycle, data 1..16 -> `stb_out` every cycle, `o_data` 1..16 in order one cycle later, `count` ≤1.
- Fill/full: `dst_rdy_i`=0, 5 items offered -> 4 captured, `count`=4, `stb_out`=0 on 5th, `overflow`=1. Release -> outputs 1,2,3,4.
- Simultaneous capture+pop at `count`=2 -> `count` stays 2, order preserved across pointer wrap (≥10 items).
- Credits: 4 launches, no pops -> `ok_to_launch`=0. 5th launch -> `underflow`=1, credits 0. One pop -> `ok_to_launch`=1 next cycle.
- Launch+pop same cycle at credits=2 -> credits stay 2. Random launch/`dst_rdy_i` with legal controller -> `overflow` never set.

Source files
------------

// File: rtl/pipe_out_buffer.sv
// rtl/pipe_out_buffer.sv - output FIFO and launch-credit manager for strobe-driven DSP pipelines
module pipe_out_buffer #(
  parameter int WIDTH      = 32,
  parameter int TAGWIDTH   = 1,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  launch_i,
  output logic                  ok_to_launch,
  input  logic                  valid_in,
  input  logic [WIDTH-1:0]      data_in,
  input  logic [TAGWIDTH-1:0]   tag_in,
  output logic                  stb_out,
  output logic [WIDTH-1:0]      o_data,
  output logic [TAGWIDTH-1:0]   o_tag,
  output logic                  src_rdy_o,
  input  logic                  dst_rdy_i,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL    = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   ONE     = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [TAGWIDTH+WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0]     wr_ptr;
  logic [DEPTH_LOG2-1:0]     rd_ptr;
  logic [DEPTH_LOG2:0]       credits;
  logic                      full;
  logic                      pop;

  assign full         = (count == FULL);
  // Gated by reset so an async reset mid-transfer kills the capture strobe at once.
  assign stb_out      = reset & valid_in & ~full;
  assign src_rdy_o    = (count != '0);
  assign pop          = src_rdy_o & dst_rdy_i;
  assign ok_to_launch = (credits != '0);
  assign {o_tag, o_data} = src_rdy_o ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (stb_out) begin
      mem[wr_ptr] <= {tag_in, data_in};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      credits   <= FULL;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (stb_out) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end

      if (stb_out && !pop) begin
        count <= count + ONE;
      end else if (pop && !stb_out) begin
        count <= count - ONE;
      end

      if (valid_in && full) begin
        overflow <= 1'b1;
      end
      if (launch_i && credits == '0) begin
        underflow <= 1'b1;
      end

      // A failed launch at zero credits cancels a same-cycle pop, so credits hold.
      if (launch_i && !pop) begin
        if (credits != '0) begin
          credits <= credits - ONE;
        end
      end else if (pop && !launch_i && credits != FULL) begin
        credits <= credits + ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipe_out_buffer.sv
// tb/tb_pipe_out_buffer.sv - randomized self-checking bench for pipe_out_buffer
module tb_pipe_out_buffer;
  localparam int W  = 32;
  localparam int TW = 1;
  localparam int DL = 2;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          launch_i = 1'b0;
  logic          valid_in = 1'b0;
  logic          dst_rdy_i = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic [TW-1:0] tag_in = '0;
  logic          ok_to_launch, stb_out, src_rdy_o, overflow, underflow;
  logic [W-1:0]  o_data;
  logic [TW-1:0] o_tag;
  logic [DL:0]   count;

  always #5 clk = ~clk;

  pipe_out_buffer #(.WIDTH(W), .TAGWIDTH(TW), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .reset(reset), .launch_i(launch_i), .ok_to_launch(ok_to_launch),
    .valid_in(valid_in), .data_in(data_in), .tag_in(tag_in), .stb_out(stb_out),
    .o_data(o_data), .o_tag(o_tag), .src_rdy_o(src_rdy_o), .dst_rdy_i(dst_rdy_i),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [TW+W-1:0] q[$];
  int              m_credits;
  bit              m_ovf, m_udf;
  logic            e_stb, e_src, e_ok;
  logic [W-1:0]    e_data;
  logic [TW-1:0]   e_tag;
  int              e_count;

  task automatic model_reset();
    q.delete();
    m_credits = D;
    m_ovf = 0;
    m_udf = 0;
  endtask

  task automatic pulse_reset();
    valid_in = 0; launch_i = 0; dst_rdy_i = 0;
    reset = 0;
    repeat (2) @(posedge clk);
    #3 reset = 1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic apply(input logic v, input logic [W-1:0] d, input logic [TW-1:0] t,
                       input logic l, input logic r);
    valid_in = v; data_in = d; tag_in = t; launch_i = l; dst_rdy_i = r;
    #1;
    e_count = q.size();
    e_stb   = v && (q.size() < D);
    e_src   = (q.size() != 0);
    {e_tag, e_data} = e_src ? q[0] : '0;
    e_ok    = (m_credits != 0);
  endtask

  task automatic advance();
    bit pop;
    pop = e_src && dst_rdy_i;
    if (valid_in && q.size() == D) m_ovf = 1;
    if (pop) void'(q.pop_front());
    if (e_stb) q.push_back({tag_in, data_in});
    if (launch_i && !pop) begin
      if (m_credits > 0) m_credits--; else m_udf = 1;
    end else if (pop && !launch_i) begin
      if (m_credits < D) m_credits++;
    end else if (launch_i && pop && m_credits == 0) begin
      m_udf = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL por_count got %0d exp 0", count); end
    n_tests++; if (ok_to_launch !== 1'b1) begin n_fail++; $display("FAIL por_ok got %b exp 1", ok_to_launch); end
    for (int i = 0; i < 2; i++) begin apply(1, $urandom, 0, 0, 0); advance(); end
    for (int i = 0; i < 5; i++) begin apply(0, 0, 0, 1, 0); advance(); end
    n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL pre_reset_udf got %b exp 1", underflow); end
    valid_in = 1; data_in = 32'hdead_beef;
    #2 reset = 0;
    #1;
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", count); end
    n_tests++; if (src_rdy_o !== 1'b0) begin n_fail++; $display("FAIL rst_src_rdy got %b exp 0", src_rdy_o); end
    n_tests++; if (stb_out !== 1'b0) begin n_fail++; $display("FAIL rst_stb got %b exp 0", stb_out); end
    n_tests++; if (o_data !== '0) begin n_fail++; $display("FAIL rst_o_data got %h exp 0", o_data); end
    n_tests++; if (ok_to_launch !== 1'b1) begin n_fail++; $display("FAIL rst_ok got %b exp 1", ok_to_launch); end
    n_tests++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL rst_flags got %b exp 00", {overflow, underflow}); end
    pulse_reset();
    for (int i = 0; i < D; i++) begin apply(0, 0, 0, 1, 0); advance(); end
    apply(0, 0, 0, 0, 0);
    n_tests++; if (ok_to_launch !== 1'b0) begin n_fail++; $display("FAIL rst_credits4 got ok=%b exp 0 after 4 launches", ok_to_launch); end
    pulse_reset();
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 16; i++) begin
      apply(1, 32'(i), TW'($urandom), 1, 1);
      n_tests++; if (stb_out !== 1'b1) begin n_fail++; $display("FAIL stream_stb i=%0d got %b exp 1", i, stb_out); end
      n_tests++; if (count > 3'd1) begin n_fail++; $display("FAIL stream_count i=%0d got %0d exp <=1", i, count); end
      if (i > 1) begin
        n_tests++; if (o_data !== 32'(i-1)) begin n_fail++; $display("FAIL stream_data i=%0d got %0d exp %0d", i, o_data, i-1); end
        n_tests++; if (o_tag !== e_tag) begin n_fail++; $display("FAIL stream_tag i=%0d got %b exp %b", i, o_tag, e_tag); end
      end
      advance();
    end
    apply(0, 0, 0, 0, 1);
    n_tests++; if (o_data !== 32'd16) begin n_fail++; $display("FAIL stream_last got %0d exp 16", o_data); end
    advance();
    apply(0, 0, 0, 0, 0);
    n_tests++; if (ok_to_launch !== e_ok || count !== 3'd0) begin n_fail++; $display("FAIL stream_end got ok=%b cnt=%0d exp ok=%b cnt=0", ok_to_launch, count, e_ok); end
  endtask

  task automatic test_fill_full();
    for (int i = 1; i <= 5; i++) begin
      apply(1, 32'(i), 0, 0, 0);
      n_tests++; if (stb_out !== (i <= 4)) begin n_fail++; $display("FAIL fill_stb i=%0d got %b exp %b", i, stb_out, i <= 4); end
      advance();
    end
    apply(0, 0, 0, 0, 0);
    n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d exp 4", count); end
    n_tests++; if (overflow !== 1'b1 || overflow !== m_ovf) begin n_fail++; $display("FAIL fill_overflow got %b exp 1", overflow); end
    for (int k = 1; k <= 4; k++) begin
      apply(0, 0, 0, 0, 1);
      n_tests++; if (o_data !== 32'(k) || src_rdy_o !== 1'b1) begin n_fail++; $display("FAIL drain_data k=%0d got %0d/%b exp %0d/1", k, o_data, src_rdy_o, k); end
      advance();
    end
    apply(0, 0, 0, 0, 0);
    n_tests++; if (src_rdy_o !== 1'b0 || o_data !== '0) begin n_fail++; $display("FAIL drain_empty got rdy=%b data=%h exp 0/0", src_rdy_o, o_data); end
    pulse_reset();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin apply(1, $urandom, TW'($urandom), 0, 0); advance(); end
    for (int i = 0; i < 12; i++) begin
      apply(1, $urandom, TW'($urandom), 0, 1);
      n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count i=%0d got %0d exp 2", i, count); end
      n_tests++; if (o_data !== e_data || o_tag !== e_tag) begin n_fail++; $display("FAIL b2b_data i=%0d got %h/%b exp %h/%b", i, o_data, o_tag, e_data, e_tag); end
      n_tests++; if (stb_out !== 1'b1) begin n_fail++; $display("FAIL b2b_stb i=%0d got %b exp 1", i, stb_out); end
      advance();
    end
    for (int i = 0; i < 2; i++) begin
      apply(0, 0, 0, 0, 1);
      n_tests++; if (o_data !== e_data) begin n_fail++; $display("FAIL b2b_drain i=%0d got %h exp %h", i, o_data, e_data); end
      advance();
    end
    pulse_reset();
  endtask

  task automatic test_credits();
    for (int i = 0; i < 2; i++) begin apply(1, $urandom, 0, 0, 0); advance(); end
    for (int k = 0; k < D; k++) begin
      apply(0, 0, 0, 1, 0);
      n_tests++; if (ok_to_launch !== 1'b1) begin n_fail++; $display("FAIL cred_ok k=%0d got %b exp 1", k, ok_to_launch); end
      advance();
    end
    apply(0, 0, 0, 0, 0);
    n_tests++; if (ok_to_launch !== 1'b0) begin n_fail++; $display("FAIL cred_zero got %b exp 0", ok_to_launch); end
    apply(0, 0, 0, 1, 0); advance();
    apply(0, 0, 0, 0, 0);
    n_tests++; if (underflow !== 1'b1 || ok_to_launch !== 1'b0) begin n_fail++; $display("FAIL cred_udf got udf=%b ok=%b exp 1/0", underflow, ok_to_launch); end
    apply(0, 0, 0, 0, 1); advance();
    apply(0, 0, 0, 0, 0);
    n_tests++; if (ok_to_launch !== 1'b1) begin n_fail++; $display("FAIL cred_pop_return got %b exp 1", ok_to_launch); end
    apply(0, 0, 0, 1, 0); advance();
    apply(0, 0, 0, 1, 1); advance();
    apply(0, 0, 0, 0, 0);
    n_tests++; if (ok_to_launch !== 1'b0 || ok_to_launch !== e_ok) begin n_fail++; $display("FAIL cred_pop_launch_zero got %b exp 0", ok_to_launch); end
    n_tests++; if (count !== 3'd0 || underflow !== 1'b1) begin n_fail++; $display("FAIL cred_final got cnt=%0d udf=%b exp 0/1", count, underflow); end
    pulse_reset();
  endtask

  task automatic test_launch_pop();
    for (int i = 0; i < 2; i++) begin apply(1, $urandom, 0, 1, 0); advance(); end
    apply(0, 0, 0, 1, 1); advance();
    apply(0, 0, 0, 1, 0); advance();
    apply(0, 0, 0, 0, 0);
    n_tests++; if (ok_to_launch !== 1'b1) begin n_fail++; $display("FAIL lp_ok1 got %b exp 1", ok_to_launch); end
    apply(0, 0, 0, 1, 0); advance();
    apply(0, 0, 0, 0, 0);
    n_tests++; if (ok_to_launch !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL lp_ok0 got ok=%b udf=%b exp 0/0", ok_to_launch, underflow); end
    pulse_reset();
  endtask

  task automatic test_random();
    int in_flight = 0;
    int errs = 0;
    logic v, l;
    for (int c = 0; c < 300; c++) begin
      l = (m_credits != 0) && ($urandom_range(0, 1) == 1);
      v = (in_flight > 0) && ($urandom_range(0, 2) != 0);
      apply(v, $urandom, TW'($urandom), l, $urandom_range(0, 2) == 0);
      if (e_stb) in_flight--;
      if (l) in_flight++;
      n_tests++;
      if (stb_out !== e_stb || src_rdy_o !== e_src || o_data !== e_data || o_tag !== e_tag ||
          ok_to_launch !== e_ok || count !== 3'(e_count)) begin
        n_fail++;
        if (errs++ < 10)
          $display("FAIL rand c=%0d got stb=%b rdy=%b d=%h t=%b ok=%b cnt=%0d exp %b %b %h %b %b %0d",
                   c, stb_out, src_rdy_o, o_data, o_tag, ok_to_launch, count,
                   e_stb, e_src, e_data, e_tag, e_ok, e_count);
      end
      advance();
    end
    apply(0, 0, 0, 0, 0);
    n_tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL rand_flags got %b%b exp 00", overflow, underflow); end
  endtask

  initial begin
    model_reset();
    reset = 0;
    repeat (2) @(posedge clk);
    #3 reset = 1;
    @(posedge clk); #1;
    test_reset();
    test_streaming();
    test_fill_full();
    test_back_to_back();
    test_credits();
    test_launch_pop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
